// File: rtl/operand_select_latch.sv
// Operand select stage: 8:1 operand mux feeding a 2-entry skid buffer.
// ready_out/valid_out come from registered occupancy only, so upstream never sees ready_in combinationally.
module operand_select_latch #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [TAGW-1:0]  sel,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] src_c,
    input  logic [WIDTH-1:0] src_d,
    input  logic [WIDTH-1:0] src_e,
    input  logic [WIDTH-1:0] src_f,
    input  logic [WIDTH-1:0] src_g,
    input  logic [WIDTH-1:0] src_h,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] data_out,
    output logic [TAGW-1:0]  sel_out,
    output logic [1:0]       count
);

    typedef struct packed {
        logic [TAGW-1:0]  sel;
        logic [WIDTH-1:0] data;
    } entry_t;

    logic [3:0][WIDTH-1:0] lo_half, hi_half;
    logic [WIDTH-1:0]      lo_word, hi_word, sel_word;
    entry_t [1:0]          mem;
    entry_t                wr_entry;
    logic                  head, tail;
    logic                  push, pop;

    // Same split as the upstream 8-way mux: sel[2] picks half, sel[1:0] picks within it.
    assign lo_half  = {src_d, src_c, src_b, src_a};
    assign hi_half  = {src_h, src_g, src_f, src_e};
    assign lo_word  = lo_half[sel[1:0]];
    assign hi_word  = hi_half[sel[1:0]];
    assign sel_word = sel[2] ? hi_word : lo_word;

    assign wr_entry = '{sel: sel, data: sel_word};

    assign ready_out = (count != 2'd2);
    assign valid_out = (count != 2'd0);
    assign push      = valid_in & ready_out;
    assign pop       = valid_out & ready_in;

    assign data_out = mem[head].data;
    assign sel_out  = mem[head].sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
            mem   <= '0;
        end else if (flush) begin
            // Pointers only; stale entry contents remain visible on data_out.
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[tail] <= wr_entry;
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
